// File: rtl/vga_timing_recovery.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_recovery
// Purpose  : Recovers pixel coordinates, display enable and timing lock from
//            incoming active-low VGA syncs; flags bad line/frame lengths.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_recovery #(
    parameter int H_ACTIVE     = 640,
    parameter int H_TOTAL      = 800,
    parameter int H_SYNC_START = 656,
    parameter int V_ACTIVE     = 480,
    parameter int V_TOTAL      = 525,
    parameter int V_SYNC_START = 490,
    parameter int LOCK_FRAMES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsync_n,
    input  logic        vsync_n,
    output logic [15:0] x,
    output logic [15:0] y,
    output logic        de,
    output logic        frame_start,
    output logic        locked,
    output logic        h_err,
    output logic        v_err
);

    localparam logic [15:0] c_h_active    = 16'(H_ACTIVE);
    localparam logic [15:0] c_h_total     = 16'(H_TOTAL);
    localparam logic [15:0] c_h_last      = 16'(H_TOTAL - 1);
    localparam logic [15:0] c_h_tmo       = 16'(H_TOTAL + 1);
    localparam logic [15:0] c_h_sync      = 16'(H_SYNC_START);
    localparam logic [15:0] c_v_active    = 16'(V_ACTIVE);
    localparam logic [15:0] c_v_total     = 16'(V_TOTAL);
    localparam logic [15:0] c_v_last      = 16'(V_TOTAL - 1);
    localparam logic [15:0] c_v_tmo       = 16'(V_TOTAL + 1);
    localparam logic [15:0] c_v_sync      = 16'(V_SYNC_START);
    localparam logic [15:0] c_lock_frames = 16'(LOCK_FRAMES);

    localparam logic [1:0] c_st_unlocked = 2'd0;
    localparam logic [1:0] c_st_acquire  = 2'd1;
    localparam logic [1:0] c_st_locked   = 2'd2;

    logic        r_hs_q, r_hs_q2, r_vs_q, r_vs_q2;
    logic [15:0] r_x, r_y, r_line_len, r_line_cnt, r_good_cnt;
    logic [1:0]  r_state;
    logic        r_h_err, r_v_err;

    logic        w_h_fall, w_v_fall, w_x_wrap;
    logic        w_h_timeout, w_v_timeout, w_h_bad, w_v_bad, w_tracking;
    logic [15:0] w_good_inc, w_good_nxt;
    logic [1:0]  w_state_nxt;

    // Sync inputs held as "low" in reset so no edge is seen on release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hs_q  <= 1'b0;
            r_hs_q2 <= 1'b0;
            r_vs_q  <= 1'b0;
            r_vs_q2 <= 1'b0;
        end else begin
            r_hs_q  <= hsync_n;
            r_hs_q2 <= r_hs_q;
            r_vs_q  <= vsync_n;
            r_vs_q2 <= r_vs_q;
        end
    end

    assign w_h_fall    = r_hs_q2 & ~r_hs_q;
    assign w_v_fall    = r_vs_q2 & ~r_vs_q;
    assign w_x_wrap    = !w_h_fall && (r_x == c_h_last);
    assign w_h_timeout = !w_h_fall && (r_line_len == c_h_tmo);
    assign w_v_timeout = !w_v_fall && (r_line_cnt == c_v_tmo);
    assign w_h_bad     = (w_h_fall && (r_line_len != c_h_total)) || w_h_timeout;
    assign w_v_bad     = (w_v_fall && (r_line_cnt != c_v_total)) || w_v_timeout;
    assign w_tracking  = (r_state != c_st_unlocked);
    assign w_good_inc  = r_good_cnt + 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x        <= '0;
            r_y        <= '0;
            r_line_len <= '0;
            r_line_cnt <= '0;
        end else begin
            if (w_h_fall)
                r_x <= c_h_sync;
            else if (w_x_wrap)
                r_x <= '0;
            else
                r_x <= r_x + 16'd1;

            // A vsync edge re-anchors y even on a line wrap.
            if (w_v_fall)
                r_y <= c_v_sync;
            else if (w_x_wrap)
                r_y <= (r_y == c_v_last) ? 16'd0 : r_y + 16'd1;

            if (w_h_fall || w_h_timeout)
                r_line_len <= 16'd1;
            else
                r_line_len <= r_line_len + 16'd1;

            if (w_v_fall || w_v_timeout)
                r_line_cnt <= w_h_fall ? 16'd1 : 16'd0;
            else if (w_h_fall)
                r_line_cnt <= r_line_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_st_unlocked;
            r_good_cnt <= '0;
            r_h_err    <= 1'b0;
            r_v_err    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_good_cnt <= w_good_nxt;
            r_h_err    <= w_h_bad && w_tracking;
            r_v_err    <= w_v_bad && w_tracking;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good_cnt;
        case (r_state)
            c_st_unlocked: begin
                if (w_v_fall) begin
                    w_state_nxt = c_st_acquire;
                    w_good_nxt  = '0;
                end
            end
            c_st_acquire: begin
                if (w_h_bad || w_v_bad) begin
                    w_state_nxt = c_st_unlocked;
                    w_good_nxt  = '0;
                end else if (w_v_fall) begin
                    if (w_good_inc >= c_lock_frames) begin
                        w_state_nxt = c_st_locked;
                        w_good_nxt  = '0;
                    end else begin
                        w_good_nxt  = w_good_inc;
                    end
                end
            end
            c_st_locked: begin
                if (w_h_bad || w_v_bad) begin
                    w_state_nxt = c_st_unlocked;
                    w_good_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = c_st_unlocked;
                w_good_nxt  = '0;
            end
        endcase
    end

    assign x           = r_x;
    assign y           = r_y;
    assign locked      = (r_state == c_st_locked);
    assign de          = locked && (r_x < c_h_active) && (r_y < c_v_active);
    assign frame_start = locked && (r_x == 16'd0) && (r_y == 16'd0);
    assign h_err       = r_h_err;
    assign v_err       = r_v_err;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_recovery.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_recovery
// Purpose  : Self-checking bench for vga_timing_recovery on a reduced raster.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_recovery;

    localparam int HA  = 16;
    localparam int HT  = 24;
    localparam int HSS = 18;
    localparam int HSW = 4;
    localparam int VA  = 10;
    localparam int VT  = 14;
    localparam int VSS = 11;
    localparam int VSW = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hsync_n = 1'b1;
    logic        vsync_n = 1'b1;
    logic [15:0] x, y;
    logic        de, frame_start, locked, h_err, v_err;

    vga_timing_recovery #(
        .H_ACTIVE(HA), .H_TOTAL(HT), .H_SYNC_START(HSS),
        .V_ACTIVE(VA), .V_TOTAL(VT), .V_SYNC_START(VSS), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .rst(rst), .hsync_n(hsync_n), .vsync_n(vsync_n),
        .x(x), .y(y), .de(de), .frame_start(frame_start),
        .locked(locked), .h_err(h_err), .v_err(v_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ex, ey, gx, gy;
        bit ede, efs, elk, eherr, everr, hdc, cx, cy;
    } rec_t;

    rec_t sb[$];
    int   n_checks = 0;
    int   n_errs   = 0;
    int   gx, gy, cur_gx, cur_gy, since_fall;
    bit   prev_hlo, prev_vlo, chk_x, chk_y, exp_lk, hold_fired, counting;
    int   cnt_de, cnt_fs;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s at gen(%0d,%0d): observed %0d expected %0d", tag, cur_gx, cur_gy, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " x"}, 32'(x), 0);
        check({tag, " y"}, 32'(y), 0);
        check({tag, " de"}, 32'(de), 0);
        check({tag, " frame_start"}, 32'(frame_start), 0);
        check({tag, " locked"}, 32'(locked), 0);
        check({tag, " h_err"}, 32'(h_err), 0);
        check({tag, " v_err"}, 32'(v_err), 0);
    endtask

    // Drive one pixel, queue what the DUT must show for it, check the oldest.
    task automatic pix(input bit hold, input bit sline, input bit vskip, input bit lk_v);
        bit   hlo, vlo, hf, vf;
        rec_t r;
        hlo = !hold && gx >= HSS && gx < HSS + HSW;
        vlo = gy >= VSS && gy < VSS + VSW;
        hf  = hlo && !prev_hlo;
        vf  = vlo && !prev_vlo;
        prev_hlo = hlo;
        prev_vlo = vlo;
        hsync_n  = !hlo;
        vsync_n  = !vlo;
        r.eherr = 0; r.everr = 0; r.hdc = 0;
        if (hf) begin
            chk_x = 1; since_fall = 0; hold_fired = 0;
            if (sline) begin r.eherr = 1; exp_lk = 0; end
        end else begin
            since_fall++;
        end
        if (hold && !hf) begin
            if (since_fall == HT + 1 && exp_lk) begin
                r.eherr = 1; exp_lk = 0; hold_fired = 1;
            end else if (hold_fired) begin
                r.hdc = 1;
            end
        end
        if (vf) begin
            chk_y = 1;
            if (vskip) begin r.everr = 1; exp_lk = 0; end
            else exp_lk = lk_v;
        end
        r.ex = gx; r.ey = gy; r.gx = gx; r.gy = gy;
        r.elk = exp_lk;
        r.ede = exp_lk && gx < HA && gy < VA;
        r.efs = exp_lk && gx == 0 && gy == 0;
        r.cx = chk_x; r.cy = chk_y;
        sb.push_back(r);
        @(posedge clk); #1;
        if (counting) begin
            cnt_de += int'(de);
            cnt_fs += int'(frame_start);
        end
        if (sb.size() >= 2) begin
            r = sb.pop_front();
            cur_gx = r.gx; cur_gy = r.gy;
            if (r.cx) check("x", 32'(x), 32'(r.ex));
            if (r.cy) check("y", 32'(y), 32'(r.ey));
            check("de", 32'(de), 32'(r.ede));
            check("frame_start", 32'(frame_start), 32'(r.efs));
            check("locked", 32'(locked), 32'(r.elk));
            if (!r.hdc) check("h_err", 32'(h_err), 32'(r.eherr));
            check("v_err", 32'(v_err), 32'(r.everr));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_zero("async reset");
        sb.delete();
        chk_x = 0; chk_y = 0; exp_lk = 0;
        repeat (3) begin
            @(posedge clk); #1;
            check_zero("held reset");
        end
        rst = 1'b0;
        prev_hlo = 1; prev_vlo = 1;
    endtask

    task automatic frame(input bit lk_v, input int short_ln, input int skip_ln,
                         input int hold_lo, input int hold_hi, input int rst_ln);
        for (int yy = 0; yy < VT; yy++) begin
            if (yy == skip_ln) continue;
            for (int xx = 0; xx < HT; xx++) begin
                if (yy == short_ln && xx == HSS - 1) continue;
                if (yy == rst_ln && xx == 5) do_reset();
                gx = xx; gy = yy;
                pix(yy >= hold_lo && yy <= hold_hi, yy == short_ln, skip_ln >= 0, lk_v);
            end
        end
    endtask

    initial begin
        counting = 0; cnt_de = 0; cnt_fs = 0;
        chk_x = 0; chk_y = 0; exp_lk = 0; since_fall = 0; hold_fired = 0;
        cur_gx = 0; cur_gy = 0; gx = 0; gy = 0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("power-on reset");
        rst = 1'b0;
        prev_hlo = 1; prev_vlo = 1;

        // Acquire and lock on nominal timing: lock at the third vsync edge.
        frame(0, -1, -1, -1, -1, -1);
        frame(0, -1, -1, -1, -1, -1);
        frame(1, -1, -1, -1, -1, -1);

        // One full locked frame period: exact de and frame_start totals.
        counting = 1;
        frame(1, -1, -1, -1, -1, -1);
        counting = 0;
        cur_gx = -1; cur_gy = -1;
        check("de per frame", 32'(cnt_de), 32'(HA * VA));
        check("frame_start per frame", 32'(cnt_fs), 32'd1);

        // Short line, then reacquire.
        frame(0, 3, -1, -1, -1, -1);
        frame(0, -1, -1, -1, -1, -1);
        frame(1, -1, -1, -1, -1, -1);

        // hsync held high for several lines, then reacquire.
        frame(0, -1, -1, 2, 5, -1);
        frame(0, -1, -1, -1, -1, -1);
        frame(1, -1, -1, -1, -1, -1);

        // Frame one line short, then reacquire.
        frame(0, -1, VSS - 1, -1, -1, -1);
        frame(0, -1, -1, -1, -1, -1);
        frame(0, -1, -1, -1, -1, -1);
        frame(1, -1, -1, -1, -1, -1);

        // Reset mid-frame while locked, then reacquire from the next vsync.
        frame(0, -1, -1, -1, -1, 4);
        frame(0, -1, -1, -1, -1, -1);
        frame(1, -1, -1, -1, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
`default_nettype wire
